button_event_decoder: RTL

//   Consumes the 4-bit debounced button/switch levels and turns them into discrete user-interface events:

---
 rtl/button_event_decoder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns debounced button levels into PRESS/RELEASE/LONG/REPEAT events on a valid/ready port.
// Define BUTTON_EVT_AUTOREPEAT_EN to emit REPEAT every REPEAT_CYCLES while a button stays in HELD.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_level,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_chan,
  output logic [1:0] evt_type,
  output logic [3:0] long_held,
  output logic [3:0] evt_overflow,
  input  logic       ovf_clr
);
`ifdef BUTTON_EVT_AUTOREPEAT_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif
  localparam logic [1:0] T_PRESS = 2'b00, T_RELEASE = 2'b01, T_LONG = 2'b10, T_REPEAT = 2'b11;
  typedef enum logic [1:0] {IDLE, DOWN, HELD} state_t;
  state_t           r_state    [4];
  state_t           w_state_nx [4];
  logic [CNT_W-1:0] r_cnt      [4];
  logic [CNT_W-1:0] w_cnt_nx   [4];
  logic [1:0]       r_pend_type[4];
  logic [1:0]       w_gen_type [4];
  logic [3:0]       r_prev, r_pend_valid, w_rise, w_fall, w_gen, w_take, w_ovf_set;
  logic [1:0]       r_ptr, w_grant;
  logic             w_any, w_load;

  assign w_rise = btn_level & ~r_prev;
  assign w_fall = ~btn_level & r_prev;

  // a release always wins over a LONG/REPEAT terminal in the same cycle
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_state_nx[c] = r_state[c];
      w_cnt_nx[c]   = '0;
      w_gen[c]      = 1'b0;
      w_gen_type[c] = T_PRESS;
      if (r_state[c] == IDLE) begin
        w_state_nx[c] = w_rise[c] ? DOWN : IDLE;
        w_gen[c]      = w_rise[c];
      end else if (w_fall[c]) begin
        w_state_nx[c] = IDLE;
        w_gen[c]      = 1'b1;
        w_gen_type[c] = T_RELEASE;
      end else if (r_state[c] == DOWN) begin
        w_gen[c]      = (r_cnt[c] == CNT_W'(LONG_CYCLES - 1));
        w_state_nx[c] = w_gen[c] ? HELD : DOWN;
        w_cnt_nx[c]   = w_gen[c] ? '0 : r_cnt[c] + 1'b1;
        w_gen_type[c] = T_LONG;
      end else if (AR_EN) begin
        w_gen[c]      = (r_cnt[c] == CNT_W'(REPEAT_CYCLES - 1));
        w_cnt_nx[c]   = w_gen[c] ? '0 : r_cnt[c] + 1'b1;
        w_gen_type[c] = T_REPEAT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        r_state[c] <= IDLE;
        r_cnt[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        r_state[c] <= w_state_nx[c];
        r_cnt[c]   <= w_cnt_nx[c];
      end
    end
  end

  // round-robin: first pending channel at or after the pointer
  always_comb begin
    w_grant = r_ptr;
    w_any   = |r_pend_valid;
    for (int k = 3; k >= 0; k--)
      w_grant = r_pend_valid[r_ptr + 2'(k)] ? r_ptr + 2'(k) : w_grant;
  end

  assign w_load    = ~evt_valid | evt_ready;
  assign w_take    = (w_load && w_any) ? 4'b0001 << w_grant : 4'b0000;
  assign w_ovf_set = w_gen & r_pend_valid & ~w_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev       <= '0;
      r_pend_valid <= '0;
      r_ptr        <= '0;
      evt_valid    <= 1'b0;
      evt_chan     <= '0;
      evt_type     <= '0;
      evt_overflow <= '0;
      for (int c = 0; c < 4; c++) r_pend_type[c] <= '0;
    end else begin
      r_prev       <= btn_level;
      r_pend_valid <= (r_pend_valid & ~w_take) | w_gen;
      evt_overflow <= (ovf_clr ? 4'b0000 : evt_overflow) | w_ovf_set;
      for (int c = 0; c < 4; c++) if (w_gen[c]) r_pend_type[c] <= w_gen_type[c];
      if (w_load) evt_valid <= w_any;
      if (w_load && w_any) begin
        evt_chan <= w_grant;
        evt_type <= r_pend_type[w_grant];
        r_ptr    <= w_grant + 2'd1;
      end
    end
  end

  always_comb begin
    long_held = '0;
    for (int c = 0; c < 4; c++) long_held[c] = (r_state[c] == HELD);
  end
endmodule
